// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_in in CLOCK_50 cycles, with a sticky stall timeout.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_chk
    $error("pwm_capture: FILT_LEN must be within 2..15");
  end

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             sd_q, sd_d;
  logic             s, rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d, timeout_q, timeout_d;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FW = 4;

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  assign rise = s & ~sd_q;
  assign fall = ~s & sd_q;

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    sd_d    = s;
  end

  // Measurement FSM: hi/per count from each rising edge; publish on the next one.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    per_d        = per_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        // A fall at saturation would overflow per in LOW, so it times out too.
        if (per_q == MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          per_d   = per_q + CNT_W'(1);
          state_d = LOW;
        end else begin
          hi_d  = hi_q + CNT_W'(1);
          per_d = per_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d   = hi_q;
          period_cnt_d = per_q;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b0;
          hi_d         = CNT_W'(1);
          per_d        = CNT_W'(1);
          state_d      = HIGH;
        end else if (per_q == MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          per_d = per_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sd_q         <= 1'b0;
      state_q      <= IDLE;
      hi_q         <= '0;
      per_q        <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sd_q         <= sd_d;
      state_q      <= state_d;
      hi_q         <= hi_d;
      per_q        <= per_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign level      = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM waveforms checked against an edge-timing model.
module tb_pwm_capture;
  localparam int unsigned CNT_W = 11;
  localparam int MAX = 2047;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, timeout, level;

  always #10 clk = ~clk;

  pwm_capture #(.CNT_W(CNT_W), .FILT_LEN(4)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .level     (level)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: tracks rising/falling edge times of the input waveform.
  typedef struct {int h; int p;} meas_t;
  meas_t expq[$];
  int    t, prev_rise, last_fall, last_h, last_p;
  bit    have_prev, fall_seen, cur_lvl;

  function automatic void model_reset();
    t         = 0;
    have_prev = 1'b0;
    fall_seen = 1'b0;
    cur_lvl   = 1'b0;
  endfunction

  function automatic void model_seg(input bit lvl, input int n);
    meas_t m;
    if (lvl && !cur_lvl) begin
      if (have_prev && fall_seen && (t - prev_rise) <= MAX && (last_fall - prev_rise) < MAX) begin
        m.h = last_fall - prev_rise;
        m.p = t - prev_rise;
        expq.push_back(m);
        last_h = m.h;
        last_p = m.p;
      end
      have_prev = 1'b1;
      prev_rise = t;
      fall_seen = 1'b0;
    end else if (!lvl && cur_lvl) begin
      last_fall = t;
      fall_seen = 1'b1;
    end
    cur_lvl = lvl;
    t += n;
  endfunction

  task automatic drive(input bit lvl, input int n);
    repeat (n) begin
      pwm_in = lvl;
      @(negedge clk);
    end
  endtask

  task automatic seg(input bit lvl, input int n);
    model_seg(lvl, n);
    drive(lvl, n);
  endtask

  // Strobe monitor: every meas_valid must match the next model measurement.
  int  cyc = 0;
  int  n_valid = 0;
  int  stamps[$];
  bit  prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (meas_valid) begin
        meas_t m;
        n_valid++;
        stamps.push_back(cyc);
        check("valid_back_to_back", 32'(prev_valid), 32'd0);
        check("strobe_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          m = expq.pop_front();
          check("high_cnt", 32'(high_cnt), 32'(m.h));
          check("period_cnt", 32'(period_cnt), 32'(m.p));
          check("timeout_at_valid", 32'(timeout), 32'd0);
        end
      end
      prev_valid <= meas_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"}, 32'(high_cnt), 32'd0);
    check({tag, "_period_cnt"}, 32'(period_cnt), 32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
  endtask

  task automatic glitch_period();
`ifdef PWM_CAPTURE_FILTER_EN
    model_seg(1'b1, 50);
    model_seg(1'b0, 50);
`else
    model_seg(1'b1, 20);
    model_seg(1'b0, 2);
    model_seg(1'b1, 28);
    model_seg(1'b0, 50);
`endif
    drive(1'b1, 20);
    drive(1'b0, 2);
    drive(1'b1, 28);
    drive(1'b0, 50);
  endtask

  initial begin
    int nv0;
    int h, l;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    model_reset();

    // Reset held while the input toggles.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      pwm_in = ~pwm_in;
      @(negedge clk);
    end
    check_all_zero("in_reset");
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seg(1'b0, 10);

    // Steady 300/700: first period silent, then strobes exactly 1000 cycles apart.
    stamps.delete();
    nv0 = n_valid;
    seg(1'b1, 300);
    seg(1'b0, 700);
    check("first_period_silent", 32'(n_valid - nv0), 32'd0);
    repeat (4) begin
      seg(1'b1, 300);
      seg(1'b0, 700);
    end
    check("steady_strobe_count", 32'(n_valid - nv0), 32'd4);
    for (int i = 1; i < stamps.size(); i++)
      check("steady_spacing", 32'(stamps[i] - stamps[i-1]), 32'd1000);

    // Duty step 10/90 -> 90/10.
    repeat (3) begin
      seg(1'b1, 10);
      seg(1'b0, 90);
    end
    repeat (3) begin
      seg(1'b1, 90);
      seg(1'b0, 10);
    end
    check("duty_step_drained", 32'(expq.size()), 32'd0);
    check("duty_step_period", 32'(period_cnt), 32'd100);

    // Random duty and period.
    repeat (20) begin
      h = int'($urandom_range(4, 200));
      l = int'($urandom_range(4, 200));
      seg(1'b1, h);
      seg(1'b0, l);
    end

    // Stalled high: timeout after MAX counts, last values held.
    nv0 = n_valid;
    seg(1'b1, 2000);
    check("timeout_before_max", 32'(timeout), 32'd0);
    seg(1'b1, 1000);
    check("timeout_after_max", 32'(timeout), 32'd1);
    check("timeout_hold_high", 32'(high_cnt), 32'(last_h));
    check("timeout_hold_period", 32'(period_cnt), 32'(last_p));
    check("timeout_one_strobe", 32'(n_valid - nv0), 32'd1);
    check("stall_level", 32'(level), 32'd1);
    seg(1'b0, 5);
    seg(1'b1, 5);
    check("timeout_sticky", 32'(timeout), 32'd1);
    seg(1'b0, 5);
    seg(1'b1, 5);
    seg(1'b0, 5);
    check("timeout_cleared", 32'(timeout), 32'd0);
    check("resume_high", 32'(high_cnt), 32'd5);
    check("resume_period", 32'(period_cnt), 32'd10);

    // Asynchronous reset in the middle of a high phase.
    model_seg(1'b1, 40);
    drive(1'b1, 20);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    drive(1'b1, 10);
    drive(1'b0, 10);
    rst_n = 1'b1;
    model_reset();
    seg(1'b0, 10);
    nv0 = n_valid;
    seg(1'b1, 30);
    seg(1'b0, 30);
    check("post_reset_silent", 32'(n_valid - nv0), 32'd0);
    seg(1'b1, 30);
    seg(1'b0, 30);
    check("post_reset_one_strobe", 32'(n_valid - nv0), 32'd1);

    // Short low glitches inside the high phase.
    repeat (4) glitch_period();
    seg(1'b1, 10);
    seg(1'b0, 20);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_high", 32'(high_cnt), 32'd50);
    check("glitch_period", 32'(period_cnt), 32'd100);
`else
    check("glitch_high", 32'(high_cnt), 32'd28);
    check("glitch_period", 32'(period_cnt), 32'd78);
`endif
    check("glitch_level", 32'(level), 32'd0);
    check("final_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
